hilo_unit: RTL and testbench
============================

// Module: hilo_unit
// PURPOSE
//   Downstream stage of the combinational divide (and multiply) array.
//   Times the multicycle path through the array with a latency counter, then
//   commits the 64-bit result to the HI/LO registers: HI = result[63:32]
//   (remainder / upper product), LO = result[31:0] (quotient / lower product).
//   Serves mfhi/mflo reads and mthi/mtlo writes.
//   Raises a stall to the datapath control while a HI/LO access conflicts with
//   an operation in flight.
// PARAMETERS
//   MUL_LAT  2  cycles from accepted start to HI/LO commit for multiply (1..15)
//   DIV_LAT  4  cycles from accepted start to HI/LO commit for divide (1..15)
// PORTS
//   clk       in   1   system clock, all state updates on rising edge
//   clr       in   1   asynchronous active-low reset
//   start     in   1   begin mul/div; array operands must already be valid
//   op_div    in   1   1 = divide, 0 = multiply; sampled with start
//   div_zero  in   1   divisor == 0; sampled with start when op_div = 1
//   result    in   64  combinational output of the mul/div array
//   hi_we     in   1   mthi write strobe
//   lo_we     in   1   mtlo write strobe
//   wdata     in   32  mthi/mtlo write data
//   rd_hi     in   1   mfhi request
//   rd_lo     in   1   mflo request
//   hi_out    out  32  HI register
//   lo_out    out  32  LO register
//   busy      out  1   operation in flight
//   done      out  1   one-cycle pulse, cycle after the HI/LO commit
//   dz        out  1   sticky divide-by-zero flag
//   stall     out  1   busy & (start | hi_we | lo_we | rd_hi | rd_lo)
// BEHAVIOUR
//   Reset (clr = 0, async): state IDLE, cnt = 0, HI = LO = 0.
//     busy, done and dz are 0. stall is 0 while clr = 0.
//   Reset mid-operation aborts with no commit.
//   States are IDLE and WAIT; cnt is 4 bits.
//   IDLE, start = 1 at edge k:
//     - latch op_div; load cnt = (op_div ? DIV_LAT : MUL_LAT) - 1; go to WAIT.
//     - latch zflag = op_div & div_zero; clear dz.
//   WAIT, cnt != 0: cnt decrements each edge.
//   WAIT, cnt == 0 at an edge:
//     - if zflag = 0: HI <= result[63:32], LO <= result[31:0].
//     - if zflag = 1: HI and LO are unchanged and dz <= 1.
//     - go to IDLE.
//   Commit lands at edge k + LAT. busy = 1 for exactly LAT cycles after edge k.
//   done = 1 for exactly the cycle after the commit edge; dz holds until the
//   next accepted start.
//   Upstream holds the array operands stable while busy = 1. The unit does not
//   re-check them.
//   hi_we/lo_we in IDLE: the register takes wdata at the edge.
//     - Both strobes together write the same wdata to HI and LO.
//   hi_we/lo_we and start in the same IDLE cycle: the write lands and start is
//   accepted; the commit later overwrites it (unless zflag = 1).
//   While busy: start, hi_we and lo_we are ignored (no state change) and stall
//   = 1; the requester holds them until stall drops.
//   rd_hi/rd_lo while busy: stall = 1. hi_out/lo_out always show the register
//   contents, never result.
//   stall is combinational from busy and the request inputs. It is 0 in the
//   done cycle, so a read issued in that cycle sees the new value.
//   Back-to-back: start in the done cycle is accepted (state is IDLE).
// TESTING
//   1. Reset, then divide 0x00000064 by 0x00000007, start at edge 1:
//      busy = 1 for 4 cycles; at edge 5 HI = 0x00000002, LO = 0x0000000E;
//      done pulses once.
//   2. Multiply with result = 0x00000001_FFFFFFFE:
//      commit at edge start + 2, HI = 0x00000001, LO = 0xFFFFFFFE.
//   3. rd_lo and hi_we = 1 (wdata = 0xDEADBEEF) while busy:
//      stall = 1 each cycle and HI is unchanged. After done, the same hi_we
//      gives HI = 0xDEADBEEF.
//   4. Divide with div_zero = 1, HI/LO preloaded to 0x11111111/0x22222222:
//      after 4 cycles HI/LO unchanged and dz = 1. The next start clears dz.
//   5. clr low 2 cycles into a divide:
//      HI = LO = 0, busy = 0, no done pulse. A fresh start then completes
//      normally.
//   6. mtlo and start in the same IDLE cycle:
//      LO takes wdata at that edge; the commit later overwrites it with
//      result[31:0].

Source files
------------

// File: rtl/hilo_unit_if.sv
// HI/LO unit bus: mul/div control, array result, mthi/mtlo/mfhi/mflo traffic.
// Pure wiring, no latency of its own.
// Backpressure is carried by stall (slave -> master).
interface hilo_unit_if;
    logic        start;
    logic        op_div;
    logic        div_zero;
    logic [63:0] result;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        rd_hi;
    logic        rd_lo;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        dz;
    logic        stall;

    // Datapath/control side: issues operations and register accesses.
    modport master (
        output start, op_div, div_zero, result, hi_we, lo_we, wdata, rd_hi, rd_lo,
        input  hi_out, lo_out, busy, done, dz, stall
    );

    // HI/LO unit side.
    modport slave (
        input  start, op_div, div_zero, result, hi_we, lo_we, wdata, rd_hi, rd_lo,
        output hi_out, lo_out, busy, done, dz, stall
    );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO registers behind the multicycle mul/div array; times the array path and commits its result.
// Commit lands MUL_LAT/DIV_LAT edges after an accepted start; done pulses the cycle after.
// While busy, start/mthi/mtlo/mfhi/mflo are held off with a combinational stall.
module hilo_unit #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic        clk,
    input  logic        clr,
    hilo_unit_if.slave  bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Counter is loaded with LAT-1 so the commit edge is the one that sees zero.
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        zflag_q, zflag_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;
    logic        done_q,  done_d;
    logic        dz_q,    dz_d;
    logic        busy;

    assign busy       = (state_q == S_WAIT);
    assign bus.busy   = busy;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;
    assign bus.done   = done_q;
    assign bus.dz     = dz_q;
    // Any request presented while an operation is in flight must be held off.
    assign bus.stall  = busy & (bus.start | bus.hi_we | bus.lo_we | bus.rd_hi | bus.rd_lo);

    // Next-state: accept start/writes in IDLE, count down and commit in WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        zflag_d = zflag_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start) begin
                    // op_div only matters here: it picks the latency and qualifies div_zero.
                    cnt_d   = bus.op_div ? DIV_CNT : MUL_CNT;
                    zflag_d = bus.op_div & bus.div_zero;
                    dz_d    = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // A zero divisor leaves HI/LO untouched and only raises dz.
                    if (!zflag_q) begin
                        hi_d = bus.result[63:32];
                        lo_d = bus.result[31:0];
                    end else begin
                        dz_d = 1'b1;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset mid-operation abandons the operation without a commit.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            zflag_q <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zflag_q <= zflag_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Testbench for hilo_unit: scenario tasks with a scoreboard of expected commits.
module tb_hilo_unit;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 4;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clk;
    logic        clr;
    hilo_unit_if hif();

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    hilo_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk (clk),
        .clr (clr),
        .bus (hif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hif.start    = 1'b0;
        hif.op_div   = 1'b0;
        hif.div_zero = 1'b0;
        hif.result   = 64'd0;
        hif.hi_we    = 1'b0;
        hif.lo_we    = 1'b0;
        hif.wdata    = 32'd0;
        hif.rd_hi    = 1'b0;
        hif.rd_lo    = 1'b0;
    endtask

    // Present start for one edge; result stays held for the whole operation.
    task automatic issue_op(input logic is_div, input logic dzin, input logic [63:0] res, input exp_t e);
        hif.start    = 1'b1;
        hif.op_div   = is_div;
        hif.div_zero = dzin;
        hif.result   = res;
        exp_q.push_back(e);
        step();
        hif.start    = 1'b0;
        hif.op_div   = 1'b0;
        hif.div_zero = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen, plus busy cycles.
    task automatic wait_done(output int edges, output int busy_cyc, output bit timed_out);
        edges    = 0;
        busy_cyc = 0;
        while (!hif.done && edges < 40) begin
            if (hif.busy) busy_cyc++;
            step();
            edges++;
        end
        timed_out = !hif.done;
    endtask

    task automatic test_reset();
        exp_t dummy;
        clear_inputs();
        clr = 1'b0;
        hif.start = 1'b1; hif.rd_hi = 1'b1; hif.hi_we = 1'b1; hif.wdata = 32'hFFFF_FFFF;
        step(); step();
        n_checks++; if (hif.hi_out !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hif.hi_out); end
        n_checks++; if (hif.lo_out !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", hif.lo_out); end
        n_checks++; if (hif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", hif.busy); end
        n_checks++; if (hif.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", hif.done); end
        n_checks++; if (hif.dz !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b expected 0", hif.dz); end
        n_checks++; if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", hif.stall); end
        clear_inputs();
        clr = 1'b1;
        step();
        dummy = '0;
        if (dummy.dz) clr = 1'b1;
    endtask

    task automatic test_div_basic();
        int e, b; bit to; exp_t ex;
        issue_op(1'b1, 1'b0, {32'h0000_0002, 32'h0000_000E}, '{hi: 32'h2, lo: 32'hE, dz: 1'b0});
        wait_done(e, b, to);
        n_checks++; if (to || e != DIV_LAT) begin n_fail++; $display("FAIL div_latency: got %0d expected %0d (timeout %0b)", e, DIV_LAT, to); end
        n_checks++; if (b != DIV_LAT) begin n_fail++; $display("FAIL div_busy_cycles: got %0d expected %0d", b, DIV_LAT); end
        ex = exp_q.pop_front();
        n_checks++; if (hif.hi_out !== ex.hi) begin n_fail++; $display("FAIL div_hi: got %h expected %h", hif.hi_out, ex.hi); end
        n_checks++; if (hif.lo_out !== ex.lo) begin n_fail++; $display("FAIL div_lo: got %h expected %h", hif.lo_out, ex.lo); end
        n_checks++; if (hif.dz !== ex.dz) begin n_fail++; $display("FAIL div_dz: got %b expected %b", hif.dz, ex.dz); end
        step();
        n_checks++; if (hif.done !== 1'b0) begin n_fail++; $display("FAIL div_done_once: got %b expected 0", hif.done); end
    endtask

    task automatic test_mul();
        int e, b; bit to; exp_t ex;
        issue_op(1'b0, 1'b1, 64'h0000_0001_FFFF_FFFE, '{hi: 32'h1, lo: 32'hFFFF_FFFE, dz: 1'b0});
        wait_done(e, b, to);
        n_checks++; if (to || e != MUL_LAT) begin n_fail++; $display("FAIL mul_latency: got %0d expected %0d (timeout %0b)", e, MUL_LAT, to); end
        n_checks++; if (b != MUL_LAT) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d expected %0d", b, MUL_LAT); end
        ex = exp_q.pop_front();
        n_checks++; if (hif.hi_out !== ex.hi) begin n_fail++; $display("FAIL mul_hi: got %h expected %h", hif.hi_out, ex.hi); end
        n_checks++; if (hif.lo_out !== ex.lo) begin n_fail++; $display("FAIL mul_lo: got %h expected %h", hif.lo_out, ex.lo); end
        n_checks++; if (hif.dz !== ex.dz) begin n_fail++; $display("FAIL mul_dz: got %b expected %b", hif.dz, ex.dz); end
        step();
    endtask

    task automatic test_stall();
        exp_t ex;
        issue_op(1'b0, 1'b0, {32'h0000_000A, 32'h0000_000B}, '{hi: 32'hA, lo: 32'hB, dz: 1'b0});
        hif.rd_lo = 1'b1;
        hif.hi_we = 1'b1;
        hif.wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 40 && hif.busy; i++) begin
            #1;
            n_checks++; if (hif.stall !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b expected 1", hif.stall); end
            n_checks++; if (hif.hi_out !== 32'h1) begin n_fail++; $display("FAIL stall_hi_hold: got %h expected 00000001", hif.hi_out); end
            step();
        end
        n_checks++; if (hif.done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b expected 1", hif.done); end
        n_checks++; if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL stall_done_cycle: got %b expected 0", hif.stall); end
        ex = exp_q.pop_front();
        n_checks++; if (hif.lo_out !== ex.lo) begin n_fail++; $display("FAIL stall_read_lo: got %h expected %h", hif.lo_out, ex.lo); end
        n_checks++; if (hif.hi_out !== ex.hi) begin n_fail++; $display("FAIL stall_commit_hi: got %h expected %h", hif.hi_out, ex.hi); end
        step();
        n_checks++; if (hif.hi_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stall_mthi_after: got %h expected deadbeef", hif.hi_out); end
        n_checks++; if (hif.lo_out !== 32'hB) begin n_fail++; $display("FAIL stall_lo_keep: got %h expected 0000000b", hif.lo_out); end
        clear_inputs();
    endtask

    task automatic test_div_zero();
        int e, b; bit to; exp_t ex;
        hif.hi_we = 1'b1; hif.wdata = 32'h1111_1111;
        step();
        hif.hi_we = 1'b0; hif.lo_we = 1'b1; hif.wdata = 32'h2222_2222;
        step();
        hif.lo_we = 1'b0;
        n_checks++; if (hif.hi_out !== 32'h1111_1111) begin n_fail++; $display("FAIL mthi: got %h expected 11111111", hif.hi_out); end
        n_checks++; if (hif.lo_out !== 32'h2222_2222) begin n_fail++; $display("FAIL mtlo: got %h expected 22222222", hif.lo_out); end
        issue_op(1'b1, 1'b1, {32'h5555_5555, 32'h6666_6666}, '{hi: 32'h1111_1111, lo: 32'h2222_2222, dz: 1'b1});
        wait_done(e, b, to);
        n_checks++; if (to || e != DIV_LAT) begin n_fail++; $display("FAIL dz_latency: got %0d expected %0d (timeout %0b)", e, DIV_LAT, to); end
        ex = exp_q.pop_front();
        n_checks++; if (hif.hi_out !== ex.hi) begin n_fail++; $display("FAIL dz_hi: got %h expected %h", hif.hi_out, ex.hi); end
        n_checks++; if (hif.lo_out !== ex.lo) begin n_fail++; $display("FAIL dz_lo: got %h expected %h", hif.lo_out, ex.lo); end
        n_checks++; if (hif.dz !== ex.dz) begin n_fail++; $display("FAIL dz_flag: got %b expected %b", hif.dz, ex.dz); end
        step(); step(); step();
        n_checks++; if (hif.dz !== 1'b1) begin n_fail++; $display("FAIL dz_sticky: got %b expected 1", hif.dz); end
        issue_op(1'b0, 1'b0, {32'h3, 32'h4}, '{hi: 32'h3, lo: 32'h4, dz: 1'b0});
        n_checks++; if (hif.dz !== 1'b0) begin n_fail++; $display("FAIL dz_cleared: got %b expected 0", hif.dz); end
        wait_done(e, b, to);
        ex = exp_q.pop_front();
        n_checks++; if (to || hif.hi_out !== ex.hi || hif.lo_out !== ex.lo) begin n_fail++; $display("FAIL dz_next_op: got %h_%h expected %h_%h", hif.hi_out, hif.lo_out, ex.hi, ex.lo); end
        step();
    endtask

    task automatic test_both_write();
        hif.hi_we = 1'b1; hif.lo_we = 1'b1; hif.wdata = 32'hA5A5_A5A5;
        step();
        clear_inputs();
        n_checks++; if (hif.hi_out !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL both_hi: got %h expected a5a5a5a5", hif.hi_out); end
        n_checks++; if (hif.lo_out !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL both_lo: got %h expected a5a5a5a5", hif.lo_out); end
    endtask

    task automatic test_reset_mid();
        int e, b; bit to; exp_t ex;
        issue_op(1'b1, 1'b0, {32'h7, 32'h8}, '{hi: 32'h7, lo: 32'h8, dz: 1'b0});
        void'(exp_q.pop_back());
        step(); step();
        clr = 1'b0;
        hif.rd_hi = 1'b1;
        #1;
        n_checks++; if (hif.hi_out !== 32'd0 || hif.lo_out !== 32'd0) begin n_fail++; $display("FAIL abort_regs: got %h_%h expected 0_0", hif.hi_out, hif.lo_out); end
        n_checks++; if (hif.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", hif.busy); end
        n_checks++; if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL abort_stall: got %b expected 0", hif.stall); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (hif.done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", hif.done); end
        end
        clr = 1'b1;
        hif.rd_hi = 1'b0;
        step();
        n_checks++; if (hif.done !== 1'b0 || hif.hi_out !== 32'd0) begin n_fail++; $display("FAIL abort_no_commit: got done %b hi %h expected 0 0", hif.done, hif.hi_out); end
        issue_op(1'b1, 1'b0, {32'h0000_0002, 32'h0000_000E}, '{hi: 32'h2, lo: 32'hE, dz: 1'b0});
        wait_done(e, b, to);
        n_checks++; if (to || e != DIV_LAT) begin n_fail++; $display("FAIL after_abort_latency: got %0d expected %0d (timeout %0b)", e, DIV_LAT, to); end
        ex = exp_q.pop_front();
        n_checks++; if (hif.hi_out !== ex.hi || hif.lo_out !== ex.lo) begin n_fail++; $display("FAIL after_abort_result: got %h_%h expected %h_%h", hif.hi_out, hif.lo_out, ex.hi, ex.lo); end
        step();
    endtask

    task automatic test_mtlo_start();
        int e, b; bit to; exp_t ex;
        hif.lo_we = 1'b1;
        hif.wdata = 32'hCAFE_F00D;
        issue_op(1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, '{hi: 32'h1234_5678, lo: 32'h9ABC_DEF0, dz: 1'b0});
        hif.lo_we = 1'b0;
        n_checks++; if (hif.lo_out !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mtlo_start_lo: got %h expected cafef00d", hif.lo_out); end
        n_checks++; if (hif.busy !== 1'b1) begin n_fail++; $display("FAIL mtlo_start_busy: got %b expected 1", hif.busy); end
        wait_done(e, b, to);
        ex = exp_q.pop_front();
        n_checks++; if (to || hif.lo_out !== ex.lo) begin n_fail++; $display("FAIL mtlo_overwrite_lo: got %h expected %h", hif.lo_out, ex.lo); end
        n_checks++; if (hif.hi_out !== ex.hi) begin n_fail++; $display("FAIL mtlo_overwrite_hi: got %h expected %h", hif.hi_out, ex.hi); end
        step();
    endtask

    task automatic test_back_to_back();
        int e, b; bit to; exp_t ex;
        issue_op(1'b0, 1'b0, {32'h1, 32'h2}, '{hi: 32'h1, lo: 32'h2, dz: 1'b0});
        wait_done(e, b, to);
        ex = exp_q.pop_front();
        n_checks++; if (to || hif.hi_out !== ex.hi || hif.lo_out !== ex.lo) begin n_fail++; $display("FAIL b2b_first: got %h_%h expected %h_%h", hif.hi_out, hif.lo_out, ex.hi, ex.lo); end
        issue_op(1'b1, 1'b0, {32'h3, 32'h4}, '{hi: 32'h3, lo: 32'h4, dz: 1'b0});
        n_checks++; if (hif.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b expected 1", hif.busy); end
        n_checks++; if (hif.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %b expected 0", hif.done); end
        wait_done(e, b, to);
        n_checks++; if (to || e != DIV_LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d (timeout %0b)", e, DIV_LAT, to); end
        ex = exp_q.pop_front();
        n_checks++; if (hif.hi_out !== ex.hi || hif.lo_out !== ex.lo) begin n_fail++; $display("FAIL b2b_second: got %h_%h expected %h_%h", hif.hi_out, hif.lo_out, ex.hi, ex.lo); end
        step();
    endtask

    initial begin
        clr = 1'b0;
        clear_inputs();
        test_reset();
        test_div_basic();
        test_mul();
        test_stall();
        test_div_zero();
        test_both_write();
        test_reset_mid();
        test_mtlo_start();
        test_back_to_back();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
